hptdc_jtag_arbiter: RTL and testbench

- Shares the single HPTDC JTAG master between N_REQ requesters, e.g. the USB command decoder (port 0) and the periodic status/readout poller (port 1).
- Arbitrates round-robin and latches the winning request.
- Sequences one complete JTAG transaction: strobe, wait for bus busy, wait for bus idle.
- Returns read data and completion status to the winner.

---
 rtl/hptdc_jtag_pkg.sv | 23 ++
 rtl/hptdc_jtag_arbiter_if.sv | 24 ++
 rtl/hptdc_rr_arbiter.sv | 42 ++++
 rtl/hptdc_jtag_arbiter.sv | 174 +++++++++++++++++
 tb/tb_hptdc_jtag_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hptdc_jtag_pkg.sv
// Shared types and constants for the HPTDC JTAG arbiter slice.
// States, default widths and HPTDC instruction codes.
package hptdc_jtag_pkg;

  localparam int N_REQ_DEF   = 2;
  localparam int DATA_W_DEF  = 749;
  localparam int INSTR_W_DEF = 5;
  localparam int TIMEOUT_DEF = 65535;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESP
  } arb_state_e;

  localparam logic [4:0] INSTR_IDCODE  = 5'h01;
  localparam logic [4:0] INSTR_SETUP   = 5'h08;
  localparam logic [4:0] INSTR_CONTROL = 5'h09;
  localparam logic [4:0] INSTR_STATUS  = 5'h0A;
  localparam logic [4:0] INSTR_BYPASS  = 5'h1F;

endpackage

// File: rtl/hptdc_jtag_arbiter_if.sv
// Bus between the arbiter and the HPTDC JTAG master.
// master: arbiter side; slave: JTAG master side.
interface hptdc_jtag_arbiter_if #(
  parameter int DATA_W  = 749,
  parameter int INSTR_W = 5
);
  logic               jm_send;
  logic               jm_get;
  logic [INSTR_W-1:0] jm_instr;
  logic [DATA_W-1:0]  jm_data_to;
  logic [DATA_W-1:0]  jm_data_from;
  logic               jm_data_received;
  logic               jm_bus_in_use;

  modport master (
    output jm_send, jm_get, jm_instr, jm_data_to,
    input  jm_data_from, jm_data_received, jm_bus_in_use
  );

  modport slave (
    input  jm_send, jm_get, jm_instr, jm_data_to,
    output jm_data_from, jm_data_received, jm_bus_in_use
  );
endinterface

// File: rtl/hptdc_rr_arbiter.sv
// Round-robin grant with registered pointer.
// Search starts one above the last winner, modulo N.
module hptdc_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          take,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = IW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take && any) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IW'(N - 1);
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/hptdc_jtag_arbiter.sv
// Shares one HPTDC JTAG master between N_REQ requesters.
// HPTDC_JTAG_ARB_TIMEOUT_EN adds a per-phase watchdog.
module hptdc_jtag_arbiter
  import hptdc_jtag_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*INSTR_W-1:0] req_instr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic                     rsp_error,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy,
  hptdc_jtag_arbiter_if.master     jm
);
  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
  begin : g_bad_cfg
    $error("hptdc_jtag_arbiter: parameter out of range");
  end

  arb_state_e         state_q, state_d;
  logic               write_q, write_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               seen_q, seen_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             any_req;
  logic             grant;

`ifdef HPTDC_JTAG_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  assign grant = (state_q == IDLE) && !jm.jm_bus_in_use && any_req;

  hptdc_rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .take    (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    instr_d = instr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    seen_d  = seen_q;
`ifdef HPTDC_JTAG_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          write_d = req_write[gnt_idx];
          instr_d = req_instr[int'(gnt_idx)*INSTR_W +: INSTR_W];
          data_d  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
          idx_d   = gnt_idx;
          seen_d  = 1'b0;
          state_d = ISSUE;
`ifdef HPTDC_JTAG_ARB_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (jm.jm_bus_in_use) begin
          state_d = WAIT_DONE;
`ifdef HPTDC_JTAG_ARB_TIMEOUT_EN
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      WAIT_DONE: begin
        if (jm.jm_data_received && !write_q) begin
          rdata_d = jm.jm_data_from;
          seen_d  = 1'b1;
        end
        // no pulse seen: whatever the master holds at idle is the answer
        if (!jm.jm_bus_in_use) begin
          state_d = RESP;
          if (!write_q && !seen_q && !jm.jm_data_received)
            rdata_d = jm.jm_data_from;
`ifdef HPTDC_JTAG_ARB_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      instr_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      seen_q  <= seen_d;
    end
  end

`ifdef HPTDC_JTAG_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_error = (state_q == RESP) && err_q;
`else
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[idx_q] = 1'b1;
  end

  assign req_ready     = (grant && rst_n) ? gnt : '0;
  assign busy          = (state_q != IDLE);
  assign rsp_data      = rdata_q;
  assign jm.jm_send    = (state_q == ISSUE) && write_q;
  assign jm.jm_get     = (state_q == ISSUE) && !write_q;
  assign jm.jm_instr   = instr_q;
  assign jm.jm_data_to = data_q;
endmodule

// File: tb/tb_hptdc_jtag_arbiter.sv
// Scoreboard bench for hptdc_jtag_arbiter with a negedge JTAG master model.
// Build with HPTDC_JTAG_ARB_TIMEOUT_EN to add the watchdog case.
module tb_hptdc_jtag_arbiter;
  import hptdc_jtag_pkg::*;

  localparam int N  = 2;
  localparam int DW = 749;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_write;
  logic [N*IW-1:0] req_instr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready, rsp_valid;
  logic            rsp_error;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  hptdc_jtag_arbiter_if #(.DATA_W(DW), .INSTR_W(IW)) jm ();

  hptdc_jtag_arbiter #(
    .N_REQ(N), .DATA_W(DW), .INSTR_W(IW), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_instr(req_instr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_error(rsp_error), .rsp_data(rsp_data),
    .busy(busy), .jm(jm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [IW-1:0] instr;
    logic [DW-1:0] data;
  } job_t;

  typedef struct {
    int            port;
    logic          err;
    logic          rd;
    logic [DW-1:0] data;
  } rsp_t;

  job_t jq[N][$];
  int   exp_gnt[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;
  logic ext_hold = 1'b0;
  logic mute = 1'b0;
  logic [DW-1:0] model_val = '0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_d(string name, logic [DW-1:0] act,
                                logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic push(input int p, input logic wr, input logic [IW-1:0] ins,
                      input logic [DW-1:0] d, input bit has_rsp,
                      input logic [DW-1:0] rd_exp, input logic err);
    job_t j;
    rsp_t r;
    j.wr = wr; j.instr = ins; j.data = d;
    jq[p].push_back(j);
    exp_gnt.push_back(p);
    if (has_rsp) begin
      r.port = p; r.err = err; r.rd = !wr; r.data = rd_exp;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #4;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      sample();
      if (jq[0].size() == 0 && jq[1].size() == 0 && exp_gnt.size() == 0 &&
          exp_rsp.size() == 0 && !busy && req_valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_drain"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_busy(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_busy"}, 64'(ok), 64'd1);
  endtask

  // requesters: hold valid until accepted, reload from the job queue
  initial begin
    logic [N-1:0] acc;
    job_t j;
    req_valid = '0; req_write = '0; req_instr = '0; req_data = '0;
    forever begin
      sample();
      acc = rst_n ? req_ready : '0;
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (req_valid[p] && acc[p]) req_valid[p] = 1'b0;
        if (!req_valid[p] && jq[p].size() > 0) begin
          j = jq[p].pop_front();
          req_valid[p] = 1'b1;
          req_write[p] = j.wr;
          req_instr[p*IW +: IW] = j.instr;
          req_data[p*DW +: DW] = j.data;
        end
      end
    end
  end

  // JTAG master model, negedge domain
  initial begin
    int cnt;
    bit rd;
    cnt = 0; rd = 1'b0;
    jm.jm_bus_in_use = 1'b0;
    jm.jm_data_received = 1'b0;
    jm.jm_data_from = '0;
    forever begin
      @(negedge clk);
      jm.jm_data_received = 1'b0;
      if (ext_hold) jm.jm_bus_in_use = 1'b1;
      else if (mute) jm.jm_bus_in_use = 1'b0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 2 && rd) begin
          jm.jm_data_received = 1'b1;
          jm.jm_data_from = model_val;
        end
        if (cnt == 0) jm.jm_bus_in_use = 1'b0;
      end else if (jm.jm_send || jm.jm_get) begin
        jm.jm_bus_in_use = 1'b1;
        rd = jm.jm_get;
        cnt = 6;
      end else jm.jm_bus_in_use = 1'b0;
    end
  end

  // scoreboard monitor
  initial begin
    int g;
    rsp_t r;
    forever begin
      sample();
      if (rst_n) begin
        if (req_ready != '0) begin
          if (exp_gnt.size() == 0) chk("unexpected_grant", 64'(req_ready), 64'd0);
          else begin
            g = exp_gnt.pop_front();
            chk("grant", 64'(req_ready), 64'd1 << g);
          end
        end
        if (rsp_valid != '0) begin
          if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          else begin
            r = exp_rsp.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'd1 << r.port);
            chk("rsp_error", 64'(rsp_error), 64'(r.err));
            if (r.rd) chk_d("rsp_data", rsp_data, r.data);
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d1;
    int n;
    bit ok;
    d1 = DW'(40'hA5A5_0000_01);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_strobes", 64'({jm.jm_send, jm.jm_get}), 64'd0);
    chk_d("rst_rsp_data", rsp_data, '0);
    rst_n = 1'b1;

    // port 0 write CONTROL
    push(0, 1'b1, INSTR_CONTROL, d1, 1'b1, '0, 1'b0);
    wait_busy("t1");
    chk("t1_send", 64'(jm.jm_send), 64'd1);
    chk("t1_get", 64'(jm.jm_get), 64'd0);
    chk("t1_instr", 64'(jm.jm_instr), 64'h09);
    chk_d("t1_data_to", jm.jm_data_to, d1);
    chk("t1_bus_up", 64'(jm.jm_bus_in_use), 64'd1);
    sample();
    chk("t1_send_dropped", 64'(jm.jm_send), 64'd0);
    chk("t1_instr_hold", 64'(jm.jm_instr), 64'h09);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (!jm.jm_bus_in_use) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t1_bus_fall", 64'(ok), 64'd1);
    chk("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
    sample();
    chk("t1_rsp_after_fall", 64'(rsp_valid), 64'd1);
    drain("t1");

    // port 1 read STATUS
    model_val = DW'(62'h1234_5678_9ABC_DEF);
    push(1, 1'b0, INSTR_STATUS, '0, 1'b1, model_val, 1'b0);
    wait_busy("t2");
    chk("t2_get", 64'(jm.jm_get), 64'd1);
    chk("t2_send", 64'(jm.jm_send), 64'd0);
    chk("t2_instr", 64'(jm.jm_instr), 64'h0A);
    drain("t2");

    // both requesters continuously valid: 0,1,0,1
    push(0, 1'b1, INSTR_SETUP, DW'(8'h11), 1'b1, '0, 1'b0);
    push(1, 1'b1, INSTR_IDCODE, DW'(8'h22), 1'b1, '0, 1'b0);
    push(0, 1'b1, INSTR_SETUP, DW'(8'h33), 1'b1, '0, 1'b0);
    push(1, 1'b1, INSTR_BYPASS, DW'(8'h44), 1'b1, '0, 1'b0);
    drain("t3");

    // bus held by an external cause: no grant until it drops
    ext_hold = 1'b1;
    sample();
    sample();
    model_val = DW'(32'hC0FF_EE01);
    push(0, 1'b0, INSTR_IDCODE, '0, 1'b1, model_val, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (req_ready != '0) n++;
    end
    chk("t4_no_grant_while_busy", 64'(n), 64'd0);
    ext_hold = 1'b0;
    drain("t4");

    // reset in WAIT_DONE abandons the transaction
    model_val = DW'(16'hBEEF);
    push(0, 1'b0, INSTR_STATUS, '0, 1'b0, '0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (busy && jm.jm_bus_in_use && !jm.jm_send && !jm.jm_get) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_wait_done", 64'(ok), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_req_ready", 64'(req_ready), 64'd0);
    chk("t5_strobes", 64'({jm.jm_send, jm.jm_get, rsp_error}), 64'd0);
    chk("t5_instr", 64'(jm.jm_instr), 64'd0);
    chk_d("t5_data_to", jm.jm_data_to, '0);
    chk_d("t5_rsp_data", rsp_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(1, 1'b1, INSTR_SETUP, DW'(12'hABC), 1'b1, '0, 1'b0);
    drain("t5");

    // lone requester regranted back-to-back
    push(0, 1'b1, INSTR_CONTROL, DW'(4'h5), 1'b1, '0, 1'b0);
    push(0, 1'b1, INSTR_CONTROL, DW'(4'h6), 1'b1, '0, 1'b0);
    drain("t6");

`ifdef HPTDC_JTAG_ARB_TIMEOUT_EN
    mute = 1'b1;
    push(0, 1'b1, INSTR_BYPASS, DW'(4'h7), 1'b1, '0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t7_busy", 64'(ok), 64'd1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (rsp_valid != '0) break;
    end
    chk("t7_timeout_cycles", 64'(n), 64'd100);
    mute = 1'b0;
    drain("t7");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
